// File: rtl/fp_datapath_seq_if.sv
// Command/data bus between the MCU/IDP side and the sequenced FP datapath.
interface fp_datapath_seq_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    CMD;
    logic [4:0]    FS;
    logic [AW-1:0] D_Addr;
    logic [AW-1:0] S_Addr;
    logic [AW-1:0] T_Addr;
    logic          T_Sel;
    logic [DW-1:0] DT;
    logic [31:0]   DY;
    logic          DY_valid;
    logic [31:0]   D_OUT;
    logic          D_OUT_vld;
    logic          busy;
    logic          done;

    modport master (
        output op_valid, CMD, FS, D_Addr, S_Addr, T_Addr, T_Sel, DT, DY, DY_valid,
        input  op_ready, D_OUT, D_OUT_vld, busy, done
    );

    modport slave (
        input  op_valid, CMD, FS, D_Addr, S_Addr, T_Addr, T_Sel, DT, DY, DY_valid,
        output op_ready, D_OUT, D_OUT_vld, busy, done
    );
endinterface

// File: rtl/fp_datapath_seq.sv
// Sequenced FP datapath: register file, pipelined FP ALU and a 32-bit beat
// interface for moving DW-bit words to and from data memory.
module fp_datapath_seq #(
    parameter int DW      = 64,
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int ALU_LAT = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    fp_datapath_seq_if.slave    bus
);
    localparam int BEATS = DW / 32;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    // Exponent width follows the IEEE binary32/64/128 layouts.
    localparam int EW = (DW == 32) ? 8 : ((DW == 64) ? 11 : 15);
    localparam int MW = DW - 1 - EW;

    localparam logic [1:0] CMD_ALU   = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;
    localparam logic [1:0] CMD_NOP   = 2'b11;

    localparam logic [4:0] FS_FADD = 5'h00;
    localparam logic [4:0] FS_FSUB = 5'h01;
    localparam logic [4:0] FS_FNEG = 5'h02;
    localparam logic [4:0] FS_FABS = 5'h03;
    localparam logic [4:0] FS_FMVT = 5'h04;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_LOAD  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 op_ready_q, op_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [31:0]          d_out_q, d_out_d;
    logic                 d_out_vld_q, d_out_vld_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        dst_q, dst_d;
    logic [DW-1:0]        asm_q, asm_d;
    logic [DW-1:0]        snap_q, snap_d;
    logic [ALU_LAT-1:0]   pv_q, pv_d;
    logic [DW-1:0]        pipe_q [ALU_LAT];
    logic [DW-1:0]        pipe_d [ALU_LAT];
    logic [DW-1:0]        rf_q [NREG];
    logic [DW-1:0]        rf_d [NREG];

    logic                 accept_s;
    logic                 rf_we_s;
    logic [AW-1:0]        rf_wa_s;
    logic [DW-1:0]        rf_wd_s;
    logic [DW-1:0]        rd_s_s, rd_t_s, t_op_s, alu_res_s, fadd_res_s;
    logic [DW-1:0]        op_b_s, big_s, sml_s;
    logic [EW-1:0]        eb_s, es_s, dexp_s;
    logic [MW:0]          mb_s, ms_s, msh_s, diff_s;
    logic [MW+1:0]        sum_s;
    logic [MW-1:0]        norm_s;
    int                   msb_s, shift_s;

    // True when a register address points at an implemented register.
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(NREG));
    endfunction

    assign accept_s = bus.op_valid & op_ready_q;
    assign rd_s_s   = in_range(bus.S_Addr) ? rf_q[bus.S_Addr] : '0;
    assign rd_t_s   = in_range(bus.T_Addr) ? rf_q[bus.T_Addr] : '0;
    assign t_op_s   = bus.T_Sel ? bus.DT : rd_t_s;

    assign bus.op_ready  = op_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.D_OUT     = d_out_q;
    assign bus.D_OUT_vld = d_out_vld_q;

    // FP add/subtract with truncation; magnitude-ordered operands, no inf/NaN handling.
    always_comb begin
        op_b_s = (bus.FS == FS_FSUB) ? {~t_op_s[DW-1], t_op_s[DW-2:0]} : t_op_s;
        if (rd_s_s[DW-2:0] >= op_b_s[DW-2:0]) begin
            big_s = rd_s_s;
            sml_s = op_b_s;
        end else begin
            big_s = op_b_s;
            sml_s = rd_s_s;
        end
        eb_s   = big_s[DW-2:MW];
        es_s   = sml_s[DW-2:MW];
        mb_s   = {|eb_s, big_s[MW-1:0]};
        ms_s   = {|es_s, sml_s[MW-1:0]};
        dexp_s = eb_s - es_s;
        msh_s  = ms_s >> dexp_s;
        sum_s  = {1'b0, mb_s} + {1'b0, msh_s};
        diff_s = mb_s - msh_s;
        msb_s  = 0;
        for (int i = 0; i <= MW; i++) begin
            msb_s = diff_s[i] ? i : msb_s;
        end
        shift_s = MW - msb_s;
        norm_s  = MW'(diff_s << shift_s);
        if (big_s[DW-1] == sml_s[DW-1]) begin
            if (sum_s[MW+1]) begin
                fadd_res_s = {big_s[DW-1], eb_s + EW'(1), sum_s[MW:1]};
            end else begin
                fadd_res_s = {big_s[DW-1], eb_s, sum_s[MW-1:0]};
            end
        end else if ((diff_s == '0) || (eb_s <= EW'(shift_s))) begin
            fadd_res_s = '0;
        end else begin
            fadd_res_s = {big_s[DW-1], eb_s - EW'(shift_s), norm_s};
        end
    end

    // ALU function select.
    always_comb begin
        case (bus.FS)
            FS_FADD, FS_FSUB: alu_res_s = fadd_res_s;
            FS_FNEG:          alu_res_s = {~rd_s_s[DW-1], rd_s_s[DW-2:0]};
            FS_FABS:          alu_res_s = {1'b0, rd_s_s[DW-2:0]};
            FS_FMVT:          alu_res_s = t_op_s;
            default:          alu_res_s = rd_s_s;
        endcase
    end

    // ALU result pipe; a valid bit travels with each result.
    always_comb begin
        pipe_d[0] = alu_res_s;
        pv_d[0]   = accept_s && (bus.CMD == CMD_ALU);
        for (int i = 1; i < ALU_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
            pv_d[i]   = pv_q[i-1];
        end
    end

    // Command FSM: next state, beat sequencing and regfile write request.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        d_out_d     = 32'h0000_0000;
        d_out_vld_d = 1'b0;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        asm_d       = asm_q;
        snap_d      = snap_q;
        rf_we_s     = 1'b0;
        rf_wa_s     = dst_q;
        rf_wd_s     = '0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    dst_d = bus.D_Addr;
                    cnt_d = '0;
                    case (bus.CMD)
                        CMD_ALU:  state_d = S_EXEC;
                        CMD_LOAD: begin
                            state_d = S_LOAD;
                            asm_d   = '0;
                        end
                        CMD_STORE: begin
                            state_d     = S_STORE;
                            d_out_d     = rd_s_s[31:0];
                            d_out_vld_d = 1'b1;
                            done_d      = (BEATS == 1);
                            snap_d      = rd_s_s >> 32;
                        end
                        CMD_NOP:  done_d = 1'b1;
                        default:  done_d = 1'b1;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (pv_q[ALU_LAT-1]) begin
                    rf_we_s = 1'b1;
                    rf_wd_s = pipe_q[ALU_LAT-1];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_LOAD: begin
                if (bus.DY_valid) begin
                    // New beat enters at the top; after BEATS beats beat 0 sits in [31:0].
                    asm_d = (asm_q >> 32) | (DW'(bus.DY) << (DW - 32));
                    if (cnt_q == LAST_BEAT) begin
                        rf_we_s = 1'b1;
                        rf_wd_s = asm_d;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_STORE: begin
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    d_out_d     = snap_q[31:0];
                    d_out_vld_d = 1'b1;
                    snap_d      = snap_q >> 32;
                    cnt_d       = cnt_q + CW'(1);
                    done_d      = (cnt_d == LAST_BEAT);
                end
            end
            default: state_d = S_IDLE;
        endcase
        op_ready_d = (state_d == S_IDLE);
        busy_d     = ~op_ready_d;
    end

    // Register file write port; reads above see the pre-write contents.
    always_comb begin
        rf_d = rf_q;
        if (rf_we_s && in_range(rf_wa_s)) begin
            rf_d[rf_wa_s] = rf_wd_s;
        end else begin
            rf_d = rf_q;
        end
    end

    // State, output and storage registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            op_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            d_out_q     <= 32'h0000_0000;
            d_out_vld_q <= 1'b0;
            cnt_q       <= '0;
            dst_q       <= '0;
            asm_q       <= '0;
            snap_q      <= '0;
            pv_q        <= '0;
            pipe_q      <= '{default: '0};
            rf_q        <= '{default: '0};
        end else begin
            state_q     <= state_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            d_out_q     <= d_out_d;
            d_out_vld_q <= d_out_vld_d;
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            asm_q       <= asm_d;
            snap_q      <= snap_d;
            pv_q        <= pv_d;
            pipe_q      <= pipe_d;
            rf_q        <= rf_d;
        end
    end
endmodule

// File: tb/tb_fp_datapath_seq.sv
// Directed bench: two 64-bit instances (ALU_LAT 1 and 3) share stimulus,
// a third 128-bit instance covers multi-beat LOAD/STORE.
module tb_fp_datapath_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_datapath_seq_if #(.DW(64),  .AW(5)) if_a ();
    fp_datapath_seq_if #(.DW(64),  .AW(5)) if_b ();
    fp_datapath_seq_if #(.DW(128), .AW(3)) if_c ();

    assign if_b.op_valid = if_a.op_valid;
    assign if_b.CMD      = if_a.CMD;
    assign if_b.FS       = if_a.FS;
    assign if_b.D_Addr   = if_a.D_Addr;
    assign if_b.S_Addr   = if_a.S_Addr;
    assign if_b.T_Addr   = if_a.T_Addr;
    assign if_b.T_Sel    = if_a.T_Sel;
    assign if_b.DT       = if_a.DT;
    assign if_b.DY       = if_a.DY;
    assign if_b.DY_valid = if_a.DY_valid;

    fp_datapath_seq #(.DW(64),  .NREG(32), .AW(5), .ALU_LAT(1)) u_a (.CLK(clk), .RESET(rst), .bus(if_a));
    fp_datapath_seq #(.DW(64),  .NREG(32), .AW(5), .ALU_LAT(3)) u_b (.CLK(clk), .RESET(rst), .bus(if_b));
    fp_datapath_seq #(.DW(128), .NREG(8),  .AW(3), .ALU_LAT(2)) u_c (.CLK(clk), .RESET(rst), .bus(if_c));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_a.op_valid = 1'b0; if_a.CMD = 2'b11; if_a.FS = 5'h00;
        if_a.D_Addr = 5'd0; if_a.S_Addr = 5'd0; if_a.T_Addr = 5'd0;
        if_a.T_Sel = 1'b0; if_a.DT = 64'h0; if_a.DY = 32'h0; if_a.DY_valid = 1'b0;
        if_c.op_valid = 1'b0; if_c.CMD = 2'b11; if_c.FS = 5'h00;
        if_c.D_Addr = 3'd0; if_c.S_Addr = 3'd0; if_c.T_Addr = 3'd0;
        if_c.T_Sel = 1'b0; if_c.DT = 128'h0; if_c.DY = 32'h0; if_c.DY_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_op_ready", 128'(if_a.op_ready), 128'd1);
        check("rst_busy", 128'(if_a.busy), 128'd0);
        check("rst_done", 128'(if_a.done), 128'd0);
        check("rst_dout", 128'(if_a.D_OUT), 128'd0);
        check("rst_dout_vld", 128'(if_a.D_OUT_vld), 128'd0);
        check("rst_c_op_ready", 128'(if_c.op_ready), 128'd1);

        // LOAD r3 with a two-cycle gap between beats
        if_a.op_valid = 1'b1; if_a.CMD = 2'b01; if_a.D_Addr = 5'd3;
        tick();
        if_a.op_valid = 1'b0; if_a.CMD = 2'b11;
        check("load_busy", 128'(if_a.busy), 128'd1);
        check("load_op_ready", 128'(if_a.op_ready), 128'd0);
        if_a.DY = 32'h0000_0000; if_a.DY_valid = 1'b1;
        tick();
        if_a.DY_valid = 1'b0;
        tick(); tick();
        check("load_gap_done", 128'(if_a.done), 128'd0);
        if_a.DY = 32'h3FF0_0000; if_a.DY_valid = 1'b1;
        tick();
        if_a.DY_valid = 1'b0;
        check("load_done", 128'(if_a.done), 128'd1);
        check("load_r3", 128'(u_a.rf_q[3]), 128'h3FF0_0000_0000_0000);
        check("load_ready_back", 128'(if_a.op_ready), 128'd1);
        tick();
        check("load_done_pulse", 128'(if_a.done), 128'd0);

        // STORE r3
        if_a.op_valid = 1'b1; if_a.CMD = 2'b10; if_a.S_Addr = 5'd3;
        tick();
        if_a.op_valid = 1'b0; if_a.CMD = 2'b11;
        check("store_b0", 128'(if_a.D_OUT), 128'h0000_0000);
        check("store_b0_vld", 128'(if_a.D_OUT_vld), 128'd1);
        check("store_b0_done", 128'(if_a.done), 128'd0);
        tick();
        check("store_b1", 128'(if_a.D_OUT), 128'h3FF0_0000);
        check("store_b1_vld", 128'(if_a.D_OUT_vld), 128'd1);
        check("store_b1_done", 128'(if_a.done), 128'd1);
        tick();
        check("store_end_vld", 128'(if_a.D_OUT_vld), 128'd0);
        check("store_end_done", 128'(if_a.done), 128'd0);
        check("store_end_ready", 128'(if_a.op_ready), 128'd1);

        // FADD r3 + DT(2.0) -> r5 = 3.0; latency 1 on u_a, 3 on u_b
        if_a.op_valid = 1'b1; if_a.CMD = 2'b00; if_a.FS = 5'h00; if_a.S_Addr = 5'd3;
        if_a.T_Sel = 1'b1; if_a.DT = 64'h4000_0000_0000_0000; if_a.D_Addr = 5'd5;
        tick();
        if_a.op_valid = 1'b0; if_a.CMD = 2'b11; if_a.T_Sel = 1'b0; if_a.DT = 64'h0;
        check("fadd_a_done0", 128'(if_a.done), 128'd0);
        check("fadd_b_done0", 128'(if_b.done), 128'd0);
        tick();
        check("fadd_a_done1", 128'(if_a.done), 128'd1);
        check("fadd_a_r5", 128'(u_a.rf_q[5]), 128'h4008_0000_0000_0000);
        check("fadd_a_ready", 128'(if_a.op_ready), 128'd1);
        check("fadd_b_done1", 128'(if_b.done), 128'd0);
        tick();
        check("fadd_a_done2", 128'(if_a.done), 128'd0);
        check("fadd_b_done2", 128'(if_b.done), 128'd0);
        tick();
        check("fadd_b_done3", 128'(if_b.done), 128'd1);
        check("fadd_b_r5", 128'(u_b.rf_q[5]), 128'h4008_0000_0000_0000);
        tick();

        // FSUB r5 - r3 (regfile T) -> r6 = 2.0
        if_a.op_valid = 1'b1; if_a.CMD = 2'b00; if_a.FS = 5'h01; if_a.S_Addr = 5'd5;
        if_a.T_Addr = 5'd3; if_a.T_Sel = 1'b0; if_a.D_Addr = 5'd6;
        tick();
        if_a.op_valid = 1'b0; if_a.CMD = 2'b11;
        tick(); tick(); tick();
        check("fsub_a_r6", 128'(u_a.rf_q[6]), 128'h4000_0000_0000_0000);
        check("fsub_b_r6", 128'(u_b.rf_q[6]), 128'h4000_0000_0000_0000);
        check("fsub_b_done", 128'(if_b.done), 128'd1);
        tick();

        // RESET after first LOAD beat to r7 aborts the command
        if_a.op_valid = 1'b1; if_a.CMD = 2'b01; if_a.D_Addr = 5'd7;
        tick();
        if_a.op_valid = 1'b0; if_a.CMD = 2'b11;
        if_a.DY = 32'hDEAD_BEEF; if_a.DY_valid = 1'b1;
        tick();
        if_a.DY = 32'h1234_5678; rst = 1'b1;
        tick();
        rst = 1'b0; if_a.DY_valid = 1'b0;
        check("abort_ready", 128'(if_a.op_ready), 128'd1);
        check("abort_busy", 128'(if_a.busy), 128'd0);
        check("abort_done", 128'(if_a.done), 128'd0);
        check("abort_r7", 128'(u_a.rf_q[7]), 128'd0);
        tick();
        check("abort_done_later", 128'(if_a.done), 128'd0);

        // op_valid held with changing CMD while busy: only the LOAD runs
        if_a.op_valid = 1'b1; if_a.CMD = 2'b01; if_a.D_Addr = 5'd1;
        tick();
        if_a.CMD = 2'b11; if_a.DY = 32'h1111_1111; if_a.DY_valid = 1'b1;
        tick();
        check("hold_busy", 128'(if_a.busy), 128'd1);
        check("hold_done", 128'(if_a.done), 128'd0);
        check("hold_vld", 128'(if_a.D_OUT_vld), 128'd0);
        if_a.CMD = 2'b10; if_a.DY = 32'h2222_2222;
        tick();
        if_a.op_valid = 1'b0; if_a.DY_valid = 1'b0; if_a.CMD = 2'b11;
        check("hold_load_done", 128'(if_a.done), 128'd1);
        check("hold_load_vld", 128'(if_a.D_OUT_vld), 128'd0);
        check("hold_r1", 128'(u_a.rf_q[1]), 128'h2222_2222_1111_1111);
        tick();
        check("hold_after_done", 128'(if_a.done), 128'd0);
        check("hold_after_vld", 128'(if_a.D_OUT_vld), 128'd0);

        // NOP completes one cycle after accept
        if_a.op_valid = 1'b1; if_a.CMD = 2'b11;
        tick();
        if_a.op_valid = 1'b0;
        check("nop_done", 128'(if_a.done), 128'd1);
        check("nop_busy", 128'(if_a.busy), 128'd0);
        tick();
        check("nop_done_pulse", 128'(if_a.done), 128'd0);

        // DW=128: four-beat LOAD to r2, then STORE r2
        if_c.op_valid = 1'b1; if_c.CMD = 2'b01; if_c.D_Addr = 3'd2;
        tick();
        if_c.op_valid = 1'b0; if_c.CMD = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if_c.DY = 32'(32'h1111_1111 * (k + 1)); if_c.DY_valid = 1'b1;
            tick();
        end
        if_c.DY_valid = 1'b0;
        check("w128_load_done", 128'(if_c.done), 128'd1);
        check("w128_r2", u_c.rf_q[2], 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        tick();
        if_c.op_valid = 1'b1; if_c.CMD = 2'b10; if_c.S_Addr = 3'd2;
        tick();
        if_c.op_valid = 1'b0; if_c.CMD = 2'b11;
        for (int k = 0; k < 4; k++) begin
            check("w128_store_beat", 128'(if_c.D_OUT), 128'(32'h1111_1111 * (k + 1)));
            check("w128_store_vld", 128'(if_c.D_OUT_vld), 128'd1);
            check("w128_store_done", 128'(if_c.done), 128'(k == 3));
            tick();
        end
        check("w128_store_end_vld", 128'(if_c.D_OUT_vld), 128'd0);
        check("w128_store_ready", 128'(if_c.op_ready), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
